// File: rtl/mbisr_repair_controller.sv
// Built-in self-repair controller: runs the BIST engine, records failing words into a
// small spare table and redirects functional accesses to repaired addresses.
module mbisr_repair_controller #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8,
   parameter int NUM_SPARES = 4,
   localparam int SU_W = $clog2(NUM_SPARES + 1),
   localparam int IW   = (NUM_SPARES > 1) ? $clog2(NUM_SPARES) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_repair_ok,
   output logic                  o_repair_fail,
   output logic [SU_W-1:0]       o_spares_used,
   output logic                  o_bist_start,
   input  logic                  i_bist_done,
   input  logic                  i_bist_fail_valid,
   input  logic [ADDR_WIDTH-1:0] i_bist_fail_addr,
   input  logic                  i_bist_mem_en,
   input  logic                  i_bist_mem_we,
   input  logic [ADDR_WIDTH-1:0] i_bist_mem_addr,
   input  logic [DATA_WIDTH-1:0] i_bist_mem_wdata,
   input  logic                  i_func_en,
   input  logic                  i_func_we,
   input  logic [ADDR_WIDTH-1:0] i_func_addr,
   input  logic [DATA_WIDTH-1:0] i_func_wdata,
   output logic                  o_func_ready,
   output logic [DATA_WIDTH-1:0] o_func_rdata,
   output logic                  o_mem_en,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_RELEASE, S_DONE} state_t;

   state_t                                  r_state;
   logic                                    r_busy, r_done, r_bist_start, r_repair_fail;
   logic [SU_W-1:0]                         r_spares_used;
   logic [NUM_SPARES-1:0]                   r_vld;
   logic [NUM_SPARES-1:0][ADDR_WIDTH-1:0]   r_taddr;
   logic [NUM_SPARES-1:0][DATA_WIDTH-1:0]   r_tdata;
   logic [DATA_WIDTH-1:0]                   r_spare_q;
   logic                                    r_hit_q;

   logic          w_hit, w_dup, w_has_free;
   logic [IW-1:0] w_hit_idx, w_free_idx;
   logic          w_func_hit;

   // Downward scans so the lowest matching/free index is the one left standing.
   always_comb begin
      w_hit      = 1'b0;
      w_hit_idx  = '0;
      w_dup      = 1'b0;
      w_has_free = 1'b0;
      w_free_idx = '0;
      for (int i = NUM_SPARES - 1; i >= 0; i--) begin
         if (r_vld[i] && r_taddr[i] == i_func_addr) begin
            w_hit     = 1'b1;
            w_hit_idx = IW'(i);
         end
         if (r_vld[i] && r_taddr[i] == i_bist_fail_addr) w_dup = 1'b1;
         if (!r_vld[i]) begin
            w_has_free = 1'b1;
            w_free_idx = IW'(i);
         end
      end
   end

   assign w_func_hit = !r_busy && i_func_en && w_hit;

   always_comb begin
      if (r_busy) begin
         o_mem_en    = i_bist_mem_en;
         o_mem_we    = i_bist_mem_we;
         o_mem_addr  = i_bist_mem_addr;
         o_mem_wdata = i_bist_mem_wdata;
      end else begin
         o_mem_en    = i_func_en && !w_hit;
         o_mem_we    = i_func_we;
         o_mem_addr  = i_func_addr;
         o_mem_wdata = i_func_wdata;
      end
   end

   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_bist_start  = r_bist_start;
   assign o_repair_fail = r_repair_fail;
   assign o_repair_ok   = r_done && !r_repair_fail;
   assign o_spares_used = r_spares_used;
   assign o_func_ready  = !r_busy;
   assign o_func_rdata  = r_hit_q ? r_spare_q : i_mem_rdata;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_bist_start  <= 1'b0;
         r_repair_fail <= 1'b0;
         r_spares_used <= '0;
         r_vld         <= '0;
         r_taddr       <= '0;
         r_tdata       <= '0;
         r_spare_q     <= '0;
         r_hit_q       <= 1'b0;
      end else begin
         r_hit_q <= w_func_hit && !i_func_we;
         if (w_func_hit && !i_func_we) r_spare_q <= r_tdata[w_hit_idx];
         if (w_func_hit && i_func_we)  r_tdata[w_hit_idx] <= i_func_wdata;

         // Repeated reports of an already repaired word are dropped.
         if (r_busy && i_bist_fail_valid && !w_dup) begin
            if (w_has_free) begin
               r_vld[w_free_idx]   <= 1'b1;
               r_taddr[w_free_idx] <= i_bist_fail_addr;
               r_tdata[w_free_idx] <= '0;
               r_spares_used       <= r_spares_used + 1'b1;
            end else begin
               r_repair_fail <= 1'b1;
            end
         end

         case (r_state)
            S_IDLE: if (i_start) begin
               r_vld         <= '0;
               r_spares_used <= '0;
               r_repair_fail <= 1'b0;
               r_bist_start  <= 1'b1;
               r_busy        <= 1'b1;
               r_state       <= S_RUN;
            end
            S_RUN: if (i_bist_done) begin
               r_bist_start <= 1'b0;
               r_state      <= S_RELEASE;
            end
            S_RELEASE: if (!i_bist_done) begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
            S_DONE: if (!i_start) begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mbisr_repair_controller.sv
// Directed bench for mbisr_repair_controller with a behavioural SRAM that has a
// stuck-at-0 word at address 5.
module tb_mbisr_repair_controller;

   logic       clk = 1'b0;
   logic       rst, start;
   logic       busy, done, repair_ok, repair_fail, bist_start;
   logic [2:0] spares_used;
   logic       bist_done, bist_fail_valid;
   logic [4:0] bist_fail_addr;
   logic       bist_mem_en, bist_mem_we;
   logic [4:0] bist_mem_addr;
   logic [7:0] bist_mem_wdata;
   logic       func_en, func_we;
   logic [4:0] func_addr;
   logic [7:0] func_wdata;
   logic       func_ready;
   logic [7:0] func_rdata;
   logic       mem_en, mem_we;
   logic [4:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;

   int n_checks = 0;
   int n_err    = 0;
   int fail_q[$];

   always #5 clk = ~clk;

   mbisr_repair_controller dut (
      .i_clk(clk), .i_rst(rst), .i_start(start),
      .o_busy(busy), .o_done(done), .o_repair_ok(repair_ok), .o_repair_fail(repair_fail),
      .o_spares_used(spares_used), .o_bist_start(bist_start),
      .i_bist_done(bist_done), .i_bist_fail_valid(bist_fail_valid), .i_bist_fail_addr(bist_fail_addr),
      .i_bist_mem_en(bist_mem_en), .i_bist_mem_we(bist_mem_we),
      .i_bist_mem_addr(bist_mem_addr), .i_bist_mem_wdata(bist_mem_wdata),
      .i_func_en(func_en), .i_func_we(func_we), .i_func_addr(func_addr), .i_func_wdata(func_wdata),
      .o_func_ready(func_ready), .o_func_rdata(func_rdata),
      .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata)
   );

   // SRAM model: 1-cycle read latency, word 5 stuck at zero.
   logic [7:0] sram [32];
   initial begin
      for (int i = 0; i < 32; i++) sram[i] = 8'h00;
      mem_rdata = 8'h00;
   end
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) sram[mem_addr] <= (mem_addr == 5'd5) ? 8'h00 : mem_wdata;
         else        mem_rdata <= sram[mem_addr];
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Full test+repair sequence; failing addresses come from fail_q, one per cycle.
   task automatic run_bist(input int exp_used, input logic exp_fail);
      start = 1'b1;
      tick;
      chk("run busy", busy, 1);
      chk("run bist_start", bist_start, 1);
      chk("run func_ready", func_ready, 0);
      foreach (fail_q[i]) begin
         bist_fail_valid = 1'b1;
         bist_fail_addr  = fail_q[i][4:0];
         tick;
      end
      bist_fail_valid = 1'b0;
      bist_done = 1'b1;
      tick;
      chk("release bist_start", bist_start, 0);
      chk("release busy", busy, 1);
      bist_done = 1'b0;
      tick;
      chk("done", done, 1);
      chk("done busy", busy, 0);
      chk("spares_used", spares_used, exp_used);
      chk("repair_fail", repair_fail, exp_fail);
      chk("repair_ok", repair_ok, !exp_fail);
      tick;
      chk("no retrigger done", done, 1);
      chk("no retrigger bist_start", bist_start, 0);
      start = 1'b0;
      tick;
      chk("back to idle", done, 0);
   endtask

   typedef struct {
      logic       en;
      logic       we;
      logic [4:0] addr;
      logic [7:0] wd;
      logic       exp_men;
      logic [7:0] exp_rd;
   } vec_t;

   task automatic apply(input vec_t v, input string tag);
      func_en = v.en; func_we = v.we; func_addr = v.addr; func_wdata = v.wd;
      #1;
      chk({tag, " mem_en"}, mem_en, v.exp_men);
      if (v.exp_men) begin
         chk({tag, " mem_addr"}, mem_addr, v.addr);
         chk({tag, " mem_we"}, mem_we, v.we);
      end
      tick;
      func_en = 1'b0;
      if (v.en && !v.we) chk({tag, " func_rdata"}, func_rdata, v.exp_rd);
   endtask

   vec_t vecs_a[8];
   vec_t vecs_b[5];

   initial begin
      vecs_a[0] = '{1, 1, 5'd5, 8'hA5, 0, 8'h00};
      vecs_a[1] = '{1, 0, 5'd5, 8'h00, 0, 8'hA5};
      vecs_a[2] = '{1, 1, 5'd6, 8'h3C, 1, 8'h00};
      vecs_a[3] = '{1, 0, 5'd6, 8'h00, 1, 8'h3C};
      vecs_a[4] = '{1, 1, 5'd7, 8'h11, 1, 8'h00};
      vecs_a[5] = '{1, 0, 5'd7, 8'h00, 1, 8'h11};
      vecs_a[6] = '{1, 0, 5'd5, 8'h00, 0, 8'hA5};
      vecs_a[7] = '{0, 0, 5'd6, 8'h00, 0, 8'h00};
      vecs_b[0] = '{1, 1, 5'd9, 8'h77, 1, 8'h00};
      vecs_b[1] = '{1, 0, 5'd9, 8'h00, 1, 8'h77};
      vecs_b[2] = '{1, 1, 5'd2, 8'h42, 0, 8'h00};
      vecs_b[3] = '{1, 0, 5'd2, 8'h00, 0, 8'h42};
      vecs_b[4] = '{1, 0, 5'd6, 8'h00, 1, 8'h3C};

      rst = 1'b1; start = 1'b0; bist_done = 1'b0; bist_fail_valid = 1'b0; bist_fail_addr = '0;
      bist_mem_en = 1'b0; bist_mem_we = 1'b0; bist_mem_addr = '0; bist_mem_wdata = '0;
      func_en = 1'b0; func_we = 1'b0; func_addr = '0; func_wdata = '0;
      tick; tick;
      rst = 1'b0;
      tick;
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset bist_start", bist_start, 0);
      chk("reset spares_used", spares_used, 0);
      chk("reset repair_fail", repair_fail, 0);
      chk("reset repair_ok", repair_ok, 0);
      chk("reset func_ready", func_ready, 1);

      // Fault-free run.
      fail_q = {};
      run_bist(0, 1'b0);

      // Word 5 reported three times -> one spare.
      fail_q = {5, 5, 5};
      run_bist(1, 1'b0);
      foreach (vecs_a[i]) apply(vecs_a[i], $sformatf("vecA%0d", i));

      // Functional requests during RUN are ignored and the port mirrors BIST.
      start = 1'b1;
      tick;
      func_en = 1'b1; func_we = 1'b1; func_addr = 5'd5; func_wdata = 8'hFF;
      bist_mem_en = 1'b1; bist_mem_we = 1'b0; bist_mem_addr = 5'd19; bist_mem_wdata = 8'h5A;
      #1;
      chk("busy func_ready", func_ready, 0);
      chk("busy mem_en", mem_en, 1);
      chk("busy mem_we", mem_we, 0);
      chk("busy mem_addr", mem_addr, 19);
      chk("busy mem_wdata", mem_wdata, 8'h5A);
      bist_mem_en = 1'b0;
      #1;
      chk("busy mem_en off", mem_en, 0);
      bist_fail_valid = 1'b1; bist_fail_addr = 5'd5;
      tick;
      tick;
      bist_fail_valid = 1'b0;
      func_en = 1'b0;
      bist_done = 1'b1;
      tick;
      bist_done = 1'b0;
      tick;
      chk("mux run done", done, 1);
      chk("mux run spares_used", spares_used, 1);
      start = 1'b0;
      tick;
      apply('{1, 0, 5'd5, 8'h00, 0, 8'h00}, "spare zeroed");

      // Overflow: five distinct fails into four spares.
      fail_q = {1, 2, 3, 4, 9};
      run_bist(4, 1'b1);
      foreach (vecs_b[i]) apply(vecs_b[i], $sformatf("vecB%0d", i));

      // New start clears the previously full table and the sticky fail.
      fail_q = {7};
      run_bist(1, 1'b0);
      apply('{1, 1, 5'd2, 8'h66, 1, 8'h00}, "cleared addr2");

      // Reset in the middle of RUN.
      start = 1'b1;
      tick;
      bist_fail_valid = 1'b1; bist_fail_addr = 5'd10;
      tick;
      bist_fail_addr = 5'd11;
      tick;
      bist_fail_valid = 1'b0;
      chk("midrun spares_used", spares_used, 2);
      chk("midrun bist_start", bist_start, 1);
      start = 1'b0;
      rst = 1'b1;
      tick;
      chk("rst bist_start", bist_start, 0);
      chk("rst spares_used", spares_used, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      rst = 1'b0;
      tick;
      chk("rst idle busy", busy, 0);
      apply('{1, 1, 5'd10, 8'h21, 1, 8'h00}, "post-rst addr10");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
